seg_scan_04: RTL and testbench

- Multiplexed 6-digit 7-segment display driver for the clock datapath.
- Sits directly downstream of the BCD seconds/minutes/hours counters and consumes their 8-bit packed-BCD outputs.
- Scans one digit at a time and shows separator points.
- Blanks the field currently being set, at a blink rate.

---
 rtl/seg_scan_04.sv | 122 ++++++++++++
 tb/tb_seg_scan_04.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_04.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_04
// Purpose  : 6-digit multiplexed 7-segment driver with tear-free frame capture,
//            separator points and field blink.
// Revision : 1.0
// ============================================================================
module seg_scan_04 #(
   parameter int SCAN_DIV    = 1000,
   parameter int BLINK_TICKS = 250
) (
   input  logic       clk_04,
   input  logic       rst_04,
   input  logic [7:0] sec_04,
   input  logic [7:0] min_04,
   input  logic [7:0] hour_04,
   input  logic [1:0] blink_sel_04,
   output logic [5:0] an_04,
   output logic [7:0] seg_04
);
   localparam int               c_PW   = $clog2(SCAN_DIV);
   localparam int               c_BW   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [c_PW-1:0]  c_PMAX = c_PW'(SCAN_DIV - 1);
   localparam logic [c_BW-1:0]  c_BMAX = c_BW'(BLINK_TICKS - 1);

   logic [c_PW-1:0] r_presc;
   logic [c_BW-1:0] r_bcnt;
   logic            r_hidden;
   logic [2:0]      r_ptr;
   logic [3:0]      r_sec_tens;
   logic [7:0]      r_min;
   logic [7:0]      r_hour;
   logic [5:0]      r_an;
   logic [7:0]      r_seg;

   logic            w_tick;
   logic [3:0]      w_nib;
   logic [1:0]      w_field;
   logic            w_dp;
   logic            w_blank;
   logic [7:0]      w_seg;

   function automatic logic [6:0] f_decode(input logic [3:0] nib);
      case (nib)
         4'd0:    f_decode = 7'h40;
         4'd1:    f_decode = 7'h79;
         4'd2:    f_decode = 7'h24;
         4'd3:    f_decode = 7'h30;
         4'd4:    f_decode = 7'h19;
         4'd5:    f_decode = 7'h12;
         4'd6:    f_decode = 7'h02;
         4'd7:    f_decode = 7'h78;
         4'd8:    f_decode = 7'h00;
         4'd9:    f_decode = 7'h10;
         default: f_decode = 7'h3F;
      endcase
   endfunction

   assign w_tick = (r_presc == c_PMAX);

   // Digit 0 reads the live seconds so it matches the shadow captured on this same tick.
   always_comb begin
      w_nib   = 4'd0;
      w_field = 2'b00;
      case (r_ptr)
         3'd0:    begin w_nib = sec_04[3:0];  w_field = 2'b01; end
         3'd1:    begin w_nib = r_sec_tens;   w_field = 2'b01; end
         3'd2:    begin w_nib = r_min[3:0];   w_field = 2'b10; end
         3'd3:    begin w_nib = r_min[7:4];   w_field = 2'b10; end
         3'd4:    begin w_nib = r_hour[3:0];  w_field = 2'b11; end
         3'd5:    begin w_nib = r_hour[7:4];  w_field = 2'b11; end
         default: begin w_nib = 4'd0;         w_field = 2'b00; end
      endcase
   end

   assign w_dp    = (r_ptr == 3'd2) || (r_ptr == 3'd4);
   assign w_seg   = {~w_dp, f_decode(w_nib)};
   assign w_blank = (r_ptr > 3'd5) ||
                    (r_hidden && (blink_sel_04 != 2'b00) && (blink_sel_04 == w_field));

   always_ff @(posedge clk_04 or negedge rst_04) begin
      if (!rst_04) begin
         r_presc    <= '0;
         r_bcnt     <= '0;
         r_hidden   <= 1'b0;
         r_ptr      <= 3'd0;
         r_sec_tens <= 4'd0;
         r_min      <= 8'd0;
         r_hour     <= 8'd0;
         r_an       <= 6'h3F;
         r_seg      <= 8'hFF;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
         if (w_tick) begin
            if (r_ptr == 3'd0) begin
               r_sec_tens <= sec_04[7:4];
               r_min      <= min_04;
               r_hour     <= hour_04;
            end
            r_ptr <= (r_ptr >= 3'd5) ? 3'd0 : r_ptr + 3'd1;
            if (r_bcnt == c_BMAX) begin
               r_bcnt   <= '0;
               r_hidden <= ~r_hidden;
            end else begin
               r_bcnt <= r_bcnt + c_BW'(1);
            end
            if (w_blank) begin
               r_an  <= 6'h3F;
               r_seg <= 8'hFF;
            end else begin
               r_an  <= ~(6'd1 << r_ptr);
               r_seg <= w_seg;
            end
         end
      end
   end

   assign an_04  = r_an;
   assign seg_04 = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_04.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_04
// Purpose  : Scoreboard bench for seg_scan_04 with a slot/frame-level reference model.
// Revision : 1.0
// ============================================================================
module tb_seg_scan_04;
   localparam int SCAN_DIV    = 4;
   localparam int BLINK_TICKS = 3;
   localparam logic [7:0] GLYPH [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                         8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   typedef struct packed {
      logic [5:0] an;
      logic [7:0] seg;
   } exp_t;

   logic       clk_04 = 1'b0;
   logic       rst_04 = 1'b0;
   logic [7:0] sec_04 = 8'h00;
   logic [7:0] min_04 = 8'h00;
   logic [7:0] hour_04 = 8'h00;
   logic [1:0] blink_sel_04 = 2'b00;
   logic [5:0] an_04;
   logic [7:0] seg_04;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   int   cur_dig = -1;

   always #5 clk_04 = ~clk_04;

   seg_scan_04 #(.SCAN_DIV(SCAN_DIV), .BLINK_TICKS(BLINK_TICKS)) u_dut (
      .clk_04      (clk_04),
      .rst_04      (rst_04),
      .sec_04      (sec_04),
      .min_04      (min_04),
      .hour_04     (hour_04),
      .blink_sel_04(blink_sel_04),
      .an_04       (an_04),
      .seg_04      (seg_04)
   );

   function automatic logic [7:0] ref_glyph(input logic [3:0] v);
      if (v <= 4'd9) ref_glyph = GLYPH[v];
      else           ref_glyph = 8'hBF;
   endfunction

   // Reference: tick k (1-based) shows digit (k-1)%6 of the frame snapshot taken at its
   // digit-0 tick; blink phase is hidden during odd-numbered runs of BLINK_TICKS ticks.
   initial begin
      int          n_cyc;
      int          s;
      int          d;
      int          field;
      bit          hidden;
      logic [23:0] frame;
      logic [3:0]  nib;
      exp_t        m_out;
      n_cyc = 0;
      frame = '0;
      m_out = '{an: 6'h3F, seg: 8'hFF};
      forever begin
         @(posedge clk_04 or negedge rst_04);
         if (!rst_04) begin
            n_cyc   = 0;
            cur_dig = -1;
            frame   = '0;
            m_out   = '{an: 6'h3F, seg: 8'hFF};
            q.delete();
            q.push_back(m_out);
         end else begin
            n_cyc++;
            if (n_cyc % SCAN_DIV == 0) begin
               s      = n_cyc / SCAN_DIV;
               d      = (s - 1) % 6;
               hidden = (((s - 1) / BLINK_TICKS) % 2) == 1;
               if (d == 0) frame = {hour_04, min_04, sec_04};
               nib   = frame[d*4 +: 4];
               field = d / 2 + 1;
               if (hidden && (int'(blink_sel_04) == field)) begin
                  m_out = '{an: 6'h3F, seg: 8'hFF};
               end else begin
                  m_out.an  = ~(6'd1 << d);
                  m_out.seg = ref_glyph(nib) & ((d == 2 || d == 4) ? 8'h7F : 8'hFF);
               end
               cur_dig = d;
            end
            q.push_back(m_out);
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk_04);
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (an_04 !== e.an || seg_04 !== e.seg) begin
               errors++;
               $display("FAIL scan t=%0t an=%h seg=%h expected an=%h seg=%h",
                        $time, an_04, seg_04, e.an, e.seg);
            end
         end
      end
   end

   task automatic check_blank(input string name);
      checks++;
      if (an_04 !== 6'h3F || seg_04 !== 8'hFF) begin
         errors++;
         $display("FAIL %s an=%h seg=%h expected an=3f seg=ff", name, an_04, seg_04);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_04);
      #2;
   endtask

   task automatic wait_dig(input int d);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         step(1);
         if (cur_dig == d) found = 1'b1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL wait_dig timeout waiting for digit %0d", d);
      end
   endtask

   task automatic async_reset(input string name);
      @(posedge clk_04);
      #3 rst_04 = 1'b0;
      #1 check_blank(name);
      step(2);
      rst_04 = 1'b1;
   endtask

   function automatic logic [3:0] rnd_nib();
      if ($urandom_range(0, 7) == 0) rnd_nib = 4'($urandom_range(10, 15));
      else                           rnd_nib = 4'($urandom_range(0, 9));
   endfunction

   initial begin
      hour_04 = 8'h12;
      min_04  = 8'h34;
      sec_04  = 8'h56;
      step(3);
      #1 check_blank("reset_hold");
      @(posedge clk_04);
      #2 rst_04 = 1'b1;
      step(60);

      sec_04 = 8'h59;
      step(30);
      wait_dig(1);
      sec_04 = 8'h00;
      step(40);

      min_04 = 8'hA3;
      step(30);

      blink_sel_04 = 2'b10;
      step(80);
      blink_sel_04 = 2'b00;

      wait_dig(4);
      async_reset("async_reset_dig4");
      step(40);

      for (int it = 0; it < 40; it++) begin
         sec_04       = {rnd_nib(), rnd_nib()};
         min_04       = {rnd_nib(), rnd_nib()};
         hour_04      = {rnd_nib(), rnd_nib()};
         blink_sel_04 = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) async_reset("async_reset_rand");
         step($urandom_range(1, 40));
      end

      step(5);
      @(negedge clk_04);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
